arp_responder_multi: RTL

// - Parametrised ARP responder between the Ethernet byte-stream MAC interface and the reply path.
// - Answers ARP requests addressed to any of NIP local IPv4 addresses.
// - Validates the full ARP header and queues up to DEPTH pending replies, so back-to-back requests are not lost.
// - Transmits replies through a request/ack handshake to the Ethernet TX arbiter.

---
 rtl/arp_responder_multi.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/arp_responder_multi.sv
// ARP responder for NIP local IPv4 addresses with a DEPTH-entry pending-reply FIFO.
// Define ARP_PAD_EN to pad each reply payload to the 46-byte Ethernet minimum.
module arp_responder_multi #(
  parameter int NIP   = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [47:0]              mac,
  input  logic [NIP*32-1:0]        ip_list,
  input  logic [NIP-1:0]           ip_valid,
  input  logic                     rx_newframehead,
  input  logic [15:0]              rx_ethertype,
  input  logic                     rx_dven,
  input  logic [7:0]               rx_data,
  input  logic                     rx_err,
  output logic                     tx_request,
  input  logic                     tx_ack,
  output logic                     tx_dven,
  output logic [7:0]               tx_data,
  output logic [47:0]              tx_smac,
  output logic [47:0]              tx_dmac,
  output logic [15:0]              tx_ethertype,
  output logic [15:0]              reply_cnt,
  output logic [15:0]              drop_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [47:0] sha;
    logic [31:0] spa;
    logic [31:0] tpa;
  } req_t;

  typedef enum logic [1:0] {RX_IDLE, RX_HEAD, RX_DRAIN, RX_CHECK} rx_st_t;
  typedef enum logic [2:0] {
    TX_IDLE, TX_REQ, TX_START, TX_HEAD,
`ifdef ARP_PAD_EN
    TX_PAD,
`endif
    TX_TAIL
  } tx_st_t;

  logic        r_nfh, r_dven, r_err;
  logic [15:0] r_et;
  logic [7:0]  r_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_nfh  <= 1'b0;
      r_dven <= 1'b0;
      r_err  <= 1'b0;
      r_et   <= '0;
      r_data <= '0;
    end else begin
      r_nfh  <= rx_newframehead;
      r_dven <= rx_dven;
      r_err  <= rx_err;
      r_et   <= rx_ethertype;
      r_data <= rx_data;
    end
  end

  // ---------------- RX ----------------
  rx_st_t         rx_st, rx_nxt;
  logic [4:0]     rx_cnt;
  logic           rx_errf;
  logic [223:0]   hdr;
  logic [NIP-1:0] ip_hit;
  logic           hdr_ok, accept;

  always_comb begin
    rx_nxt = rx_st;
    case (rx_st)
      RX_IDLE:  if (r_nfh && r_et == 16'h0806) rx_nxt = RX_HEAD;
      RX_HEAD:  if (!r_dven) rx_nxt = RX_IDLE;
                else if (rx_cnt == 5'd27) rx_nxt = RX_DRAIN;
      RX_DRAIN: if (!r_dven) rx_nxt = RX_CHECK;
      RX_CHECK: rx_nxt = RX_IDLE;
      default:  rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_st   <= RX_IDLE;
      rx_cnt  <= '0;
      rx_errf <= 1'b0;
      hdr     <= '0;
    end else begin
      rx_st <= rx_nxt;
      if (rx_st == RX_IDLE) begin
        rx_cnt  <= '0;
        rx_errf <= 1'b0;
      end else if (rx_st == RX_HEAD && r_dven) begin
        hdr     <= {hdr[215:0], r_data};
        rx_cnt  <= rx_cnt + 5'd1;
        rx_errf <= rx_errf | r_err;
      end
    end
  end

  // Only the matched TPA is queued, so any hit is equivalent to the lowest one.
  always_comb begin
    ip_hit = '0;
    for (int k = 0; k < NIP; k++)
      ip_hit[k] = ip_valid[k] && (ip_list[32*k +: 32] == hdr[31:0]);
  end

  assign hdr_ok = !rx_errf && hdr[223:208] == 16'h0001 && hdr[207:192] == 16'h0800 &&
                  hdr[191:184] == 8'd6 && hdr[183:176] == 8'd4 && hdr[175:160] == 16'h0001;
  assign accept = (rx_st == RX_CHECK) && hdr_ok && |ip_hit;

  // ---------------- FIFO ----------------
  req_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, push, pop;
  req_t          q;
  tx_st_t        tx_st, tx_nxt;

  assign full = (fifo_level == (AW+1)'(DEPTH));
  assign push = accept && !full;
  assign pop  = (tx_st == TX_START);
  assign q    = mem[rd_ptr];

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= '{sha: hdr[159:112], spa: hdr[111:80], tpa: hdr[31:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      drop_cnt   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: ;
      endcase
      if (accept && full && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // ---------------- TX ----------------
  logic [4:0]   tx_cnt;
  logic [223:0] tx_sh;

  always_comb begin
    tx_nxt = tx_st;
    case (tx_st)
      TX_IDLE:  if (fifo_level != '0) tx_nxt = TX_REQ;
      TX_REQ:   if (tx_ack) tx_nxt = TX_START;
      TX_START: tx_nxt = TX_HEAD;
`ifdef ARP_PAD_EN
      TX_HEAD:  if (tx_cnt == 5'd27) tx_nxt = TX_PAD;
      TX_PAD:   if (tx_cnt == 5'd17) tx_nxt = TX_TAIL;
`else
      TX_HEAD:  if (tx_cnt == 5'd27) tx_nxt = TX_TAIL;
`endif
      TX_TAIL:  tx_nxt = TX_IDLE;
      default:  tx_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_st     <= TX_IDLE;
      tx_cnt    <= '0;
      tx_sh     <= '0;
      tx_smac   <= '0;
      tx_dmac   <= '0;
      reply_cnt <= '0;
    end else begin
      tx_st <= tx_nxt;
      case (tx_st)
        TX_START: begin
          tx_sh   <= {16'h0001, 16'h0800, 8'd6, 8'd4, 16'h0002, mac, q.tpa, q.sha, q.spa};
          tx_smac <= mac;
          tx_dmac <= q.sha;
          tx_cnt  <= '0;
        end
        TX_HEAD: begin
          tx_sh  <= {tx_sh[215:0], 8'h00};
          tx_cnt <= (tx_cnt == 5'd27) ? 5'd0 : tx_cnt + 5'd1;
        end
`ifdef ARP_PAD_EN
        TX_PAD:  tx_cnt <= tx_cnt + 5'd1;
`endif
        TX_TAIL: if (reply_cnt != 16'hFFFF) reply_cnt <= reply_cnt + 16'd1;
        default: ;
      endcase
    end
  end

  assign tx_request   = (tx_st == TX_REQ);
`ifdef ARP_PAD_EN
  assign tx_dven      = (tx_st == TX_HEAD) || (tx_st == TX_PAD);
`else
  assign tx_dven      = (tx_st == TX_HEAD);
`endif
  assign tx_data      = (tx_st == TX_HEAD) ? tx_sh[223:216] : 8'h00;
  assign tx_ethertype = 16'h0806;

endmodule
